// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// A PC register drives one outstanding instruction-memory request. A 3-state
// controller manages the IF/ID register:
//   FETCH   - a request is outstanding at r_pc.
//   HOLD    - the response arrived under stall and is parked in a buffer.
//   DISCARD - a redirect arrived while a request was outstanding. The stale
//             response must still be drained before the new target is fetched.
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   IF_stall_i                     hazard stall; holds the PC and IF/ID
//   IF_redirect_i/IF_redirect_pc_i taken branch/jump and its target
//   imem_read_o/imem_address_o     instruction memory request
//   imem_rdata_i/imem_resp_i       returned instruction and 1-cycle strobe
//   IF_instr_o/IF_pc_out_o         registered IF/ID instruction and PC
//   IF_valid_o                     registered valid; 0 marks a bubble
module fetch_stage #(
  parameter int unsigned       width     = 32,
  parameter logic [width-1:0]  RESET_PC  = 32'h6000_0000,
  parameter logic [width-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_stall_i,
  input  logic             IF_redirect_i,
  input  logic [width-1:0] IF_redirect_pc_i,
  output logic             imem_read_o,
  output logic [width-1:0] imem_address_o,
  input  logic [width-1:0] imem_rdata_i,
  input  logic             imem_resp_i,
  output logic [width-1:0] IF_instr_o,
  output logic [width-1:0] IF_pc_out_o,
  output logic             IF_valid_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [width-1:0] r_pc,        w_pc_nxt;
  logic [width-1:0] r_target,    w_target_nxt;
  logic [width-1:0] r_buf_instr, w_buf_instr_nxt;
  logic [width-1:0] r_buf_pc,    w_buf_pc_nxt;
  logic [width-1:0] r_if_instr,  w_if_instr_nxt;
  logic [width-1:0] r_if_pc,     w_if_pc_nxt;
  logic             r_if_valid,  w_if_valid_nxt;
  logic [width-1:0] w_pc_inc;

  assign w_pc_inc       = r_pc + width'(4);
  assign imem_address_o = r_pc;
  assign imem_read_o    = !rst && (r_state != HOLD);
  assign IF_instr_o     = r_if_instr;
  assign IF_pc_out_o    = r_if_pc;
  assign IF_valid_o     = r_if_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_target_nxt    = r_target;
    w_buf_instr_nxt = r_buf_instr;
    w_buf_pc_nxt    = r_buf_pc;
    // IF/ID defaults to "hold"
    w_if_instr_nxt  = r_if_instr;
    w_if_pc_nxt     = r_if_pc;
    w_if_valid_nxt  = r_if_valid;

    unique case (r_state)
      FETCH: begin
        if (IF_redirect_i) begin
          w_if_instr_nxt = NOP_INSTR;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b0;
          if (imem_resp_i) begin
            w_pc_nxt = IF_redirect_pc_i;
          end else begin
            // Request still in flight: the address must not move until
            // the stale response has been drained.
            w_target_nxt = IF_redirect_pc_i;
            w_state_nxt  = DISCARD;
          end
        end else if (imem_resp_i) begin
          if (IF_stall_i) begin
            w_buf_instr_nxt = imem_rdata_i;
            w_buf_pc_nxt    = r_pc;
            w_state_nxt     = HOLD;
          end else begin
            w_if_instr_nxt = imem_rdata_i;
            w_if_pc_nxt    = r_pc;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc_inc;
          end
        end else if (!IF_stall_i) begin
          w_if_instr_nxt = NOP_INSTR;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        // No request is outstanding here, so imem_resp_i is ignored.
        if (IF_redirect_i) begin
          w_buf_instr_nxt = '0;
          w_buf_pc_nxt    = '0;
          w_pc_nxt        = IF_redirect_pc_i;
          w_if_instr_nxt  = NOP_INSTR;
          w_if_pc_nxt     = r_pc;
          w_if_valid_nxt  = 1'b0;
          w_state_nxt     = FETCH;
        end else if (!IF_stall_i) begin
          w_if_instr_nxt = r_buf_instr;
          w_if_pc_nxt    = r_buf_pc;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = FETCH;
        end
      end

      DISCARD: begin
        if (IF_redirect_i) begin
          w_target_nxt = IF_redirect_pc_i;
        end
        if (IF_redirect_i || !IF_stall_i) begin
          w_if_instr_nxt = NOP_INSTR;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b0;
        end
        if (imem_resp_i) begin
          w_pc_nxt    = IF_redirect_i ? IF_redirect_pc_i : r_target;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_target    <= '0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_if_instr  <= NOP_INSTR;
      r_if_pc     <= '0;
      r_if_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_target    <= w_target_nxt;
      r_buf_instr <= w_buf_instr_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_if_instr  <= w_if_instr_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_valid  <= w_if_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: streaming, stall-on-response,
// redirects with a pending request, redirect in HOLD, reset mid-DISCARD.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        resp;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .width    (32),
    .RESET_PC (32'h6000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_stall_i      (stall),
    .IF_redirect_i   (redir),
    .IF_redirect_pc_i(redir_pc),
    .imem_read_o     (rd),
    .imem_address_o  (addr),
    .imem_rdata_i    (rdata),
    .imem_resp_i     (resp),
    .IF_instr_o      (if_instr),
    .IF_pc_out_o     (if_pc),
    .IF_valid_o      (if_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall    = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    resp     = 1'b0;
    rdata    = '0;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic valid);
    check({tag, ".instr"}, if_instr, instr);
    check({tag, ".pc"}, if_pc, pc);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
  endtask

  task automatic check_req(input string tag, input logic read, input logic [31:0] a);
    check({tag, ".read"}, {31'd0, rd}, {31'd0, read});
    if (read) check({tag, ".addr"}, addr, a);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    // Reset state
    check_ifid("reset", NOP, 32'h0, 1'b0);
    check("reset.read", {31'd0, rd}, 32'd0);
    rst = 1'b0;
    #1;
    check_req("first_req", 1'b1, RPC);

    // Streaming: rdata = address, response every cycle
    for (int i = 0; i < 3; i++) begin
      resp  = 1'b1;
      rdata = RPC + 32'(4 * i);
      check_req($sformatf("stream%0d.req", i), 1'b1, RPC + 32'(4 * i));
      step();
      check_ifid($sformatf("stream%0d", i), RPC + 32'(4 * i), RPC + 32'(4 * i), 1'b1);
    end
    // Stall with no response holds the last load
    resp  = 1'b0;
    stall = 1'b1;
    step();
    check_ifid("fetch_stall_hold", 32'h6000_0008, 32'h6000_0008, 1'b1);
    // No response, no stall: bubble with pc_out = current PC
    stall = 1'b0;
    step();
    check_ifid("fetch_bubble", NOP, 32'h6000_000C, 1'b0);
    check_req("fetch_bubble.req", 1'b1, 32'h6000_000C);

    // Stall on response, 3 stall cycles; resp in HOLD must be ignored
    do_reset();
    resp  = 1'b1;
    rdata = 32'h00A0_0093;
    stall = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      check_req($sformatf("hold%0d.req", i), 1'b0, 32'h0);
      check_ifid($sformatf("hold%0d", i), NOP, 32'h0, 1'b0);
      resp  = 1'b1;
      rdata = 32'hDEAD_BEEF;
      step();
    end
    check_req("hold2.req", 1'b0, 32'h0);
    check_ifid("hold2", NOP, 32'h0, 1'b0);
    stall = 1'b0;
    resp  = 1'b0;
    step();
    check_ifid("hold_release", 32'h00A0_0093, RPC, 1'b1);
    check_req("hold_release.req", 1'b1, 32'h6000_0004);

    // Redirect with request pending; response at cycle 3
    do_reset();
    redir    = 1'b1;
    redir_pc = 32'h6000_0100;
    step();
    idle_inputs();
    check_ifid("disc0", NOP, RPC, 1'b0);
    for (int i = 1; i < 3; i++) begin
      check_req($sformatf("disc%0d.req", i), 1'b1, RPC);
      step();
      check("disc.valid", {31'd0, if_valid}, 32'd0);
    end
    check_req("disc3.req", 1'b1, RPC);
    resp  = 1'b1;
    rdata = 32'hDEAD_BEEF;
    step();
    check_ifid("disc_drain", NOP, RPC, 1'b0);
    check_req("disc_target.req", 1'b1, 32'h6000_0100);
    rdata = 32'h1111_1111;
    step();
    check_ifid("disc_after", 32'h1111_1111, 32'h6000_0100, 1'b1);

    // Double redirect in DISCARD: last target wins
    do_reset();
    redir    = 1'b1;
    redir_pc = 32'h6000_0100;
    step();
    redir_pc = 32'h6000_0200;
    step();
    redir = 1'b0;
    resp  = 1'b1;
    rdata = 32'hDEAD_BEEF;
    step();
    check_req("double_redir.req", 1'b1, 32'h6000_0200);
    check("double_redir.valid", {31'd0, if_valid}, 32'd0);

    // Redirect coincident with the draining response in DISCARD
    do_reset();
    redir    = 1'b1;
    redir_pc = 32'h6000_0100;
    step();
    redir_pc = 32'h6000_0300;
    resp     = 1'b1;
    step();
    check_req("disc_redir_resp.req", 1'b1, 32'h6000_0300);

    // FETCH response with redirect: rdata dropped, bubble, fetch target
    do_reset();
    resp     = 1'b1;
    rdata    = 32'hDDDD_DDDD;
    redir    = 1'b1;
    redir_pc = 32'h6000_0500;
    step();
    check_ifid("fetch_redir", NOP, RPC, 1'b0);
    check_req("fetch_redir.req", 1'b1, 32'h6000_0500);

    // Redirect plus stall in HOLD
    do_reset();
    resp  = 1'b1;
    rdata = 32'hAAAA_AAAA;
    stall = 1'b1;
    step();
    resp     = 1'b0;
    redir    = 1'b1;
    redir_pc = 32'h6000_0400;
    step();
    check_ifid("hold_redir", NOP, RPC, 1'b0);
    check_req("hold_redir.req", 1'b1, 32'h6000_0400);
    idle_inputs();
    resp  = 1'b1;
    rdata = 32'hBBBB_BBBB;
    step();
    check_ifid("hold_redir_after", 32'hBBBB_BBBB, 32'h6000_0400, 1'b1);

    // Reset mid-DISCARD with late response
    do_reset();
    redir    = 1'b1;
    redir_pc = 32'h6000_0100;
    step();
    redir = 1'b0;
    rst   = 1'b1;
    resp  = 1'b1;
    rdata = 32'hCCCC_CCCC;
    step();
    check_ifid("rst_disc", NOP, 32'h0, 1'b0);
    check("rst_disc.read", {31'd0, rd}, 32'd0);
    rst  = 1'b0;
    resp = 1'b0;
    #1;
    check_req("rst_disc.req", 1'b1, RPC);
    resp  = 1'b1;
    rdata = 32'h1234_5678;
    step();
    check_ifid("rst_disc_after", 32'h1234_5678, RPC, 1'b1);

    // PC increment wraps modulo 2^32
    do_reset();
    resp     = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    step();
    redir = 1'b0;
    rdata = 32'h0000_0001;
    step();
    check_ifid("wrap", 32'h0000_0001, 32'hFFFF_FFFC, 1'b1);
    check_req("wrap.req", 1'b1, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the bench always terminates.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
